// File: rtl/eda_global_define.sv
// Shared configuration and state encoding for the regional-max seed scheduler.
package eda_global_define;

  localparam int unsigned CFG_I_WIDTH    = 6;
  localparam int unsigned CFG_J_WIDTH    = 6;
  localparam int unsigned CFG_ADDR_WIDTH = 12;

  typedef enum logic [2:0] {
    SCAN_IDLE  = 3'd0,
    SCAN_FETCH = 3'd1,
    SCAN_WAIT  = 3'd2,
    SCAN_HOLD  = 3'd3,
    SCAN_DONE  = 3'd4
  } scan_state_e;

  typedef struct packed {
    logic rd_en;
    logic next_valid;
    logic busy;
    logic done;
  } scan_out_t;

  // Output flags as a pure function of the state they are registered alongside.
  function automatic scan_out_t scan_decode(input scan_state_e state);
    scan_out_t out;
    out            = '0;
    out.rd_en      = (state == SCAN_FETCH);
    out.next_valid = (state == SCAN_HOLD);
    out.busy       = (state == SCAN_FETCH) || (state == SCAN_WAIT) || (state == SCAN_HOLD);
    out.done       = (state == SCAN_DONE);
    return out;
  endfunction

endpackage

// File: rtl/eda_raster_ptr.sv
// Row-major raster pointer: steps col then row, flags the last pixel and never wraps past it.
module eda_raster_ptr
  import eda_global_define::*;
#(
  parameter int unsigned I_WIDTH = CFG_I_WIDTH,
  parameter int unsigned J_WIDTH = CFG_J_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_step,
  input  logic [I_WIDTH:0]   i_num_rows,
  input  logic [J_WIDTH:0]   i_num_cols,
  output logic [I_WIDTH-1:0] o_row,
  output logic [J_WIDTH-1:0] o_col,
  output logic               o_is_last
);

  logic [I_WIDTH-1:0] r_row;
  logic [J_WIDTH-1:0] r_col;
  logic [I_WIDTH:0]   w_row_inc;
  logic [J_WIDTH:0]   w_col_inc;
  logic               w_col_wrap;

  // One extra bit so a full-width dimension (e.g. 64) compares correctly.
  assign w_row_inc  = {1'b0, r_row} + {{I_WIDTH{1'b0}}, 1'b1};
  assign w_col_inc  = {1'b0, r_col} + {{J_WIDTH{1'b0}}, 1'b1};
  assign w_col_wrap = (w_col_inc == i_num_cols);
  assign o_is_last  = w_col_wrap && (w_row_inc == i_num_rows);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_step && !o_is_last) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_inc[I_WIDTH-1:0];
      end else begin
        r_col <= w_col_inc[J_WIDTH-1:0];
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;

endmodule

// File: rtl/eda_scan_scheduler.sv
// Raster-scan seed scheduler: presents the next unvisited pixel to the region controller.
module eda_scan_scheduler
  import eda_global_define::*;
#(
  parameter int unsigned I_WIDTH    = CFG_I_WIDTH,
  parameter int unsigned J_WIDTH    = CFG_J_WIDTH,
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [I_WIDTH:0]      i_num_rows,
  input  logic [J_WIDTH:0]      i_num_cols,
  input  logic                  i_advance,
  output logic                  o_vis_rd_en,
  output logic [ADDR_WIDTH-1:0] o_vis_rd_addr,
  input  logic                  i_vis_rd_data,
  output logic [I_WIDTH-1:0]    o_next_row,
  output logic [J_WIDTH-1:0]    o_next_col,
  output logic                  o_next_valid,
  output logic                  o_iterated_all,
  output logic [ADDR_WIDTH:0]   o_seed_count,
  output logic                  o_busy
);

  scan_state_e         r_state;
  scan_state_e         w_state_d;
  scan_out_t           r_out;
  logic [I_WIDTH:0]    r_num_rows;
  logic [J_WIDTH:0]    r_num_cols;
  logic [ADDR_WIDTH:0] r_seed_count;
  logic [I_WIDTH-1:0]  r_next_row;
  logic [J_WIDTH-1:0]  r_next_col;
  logic [I_WIDTH-1:0]  w_row;
  logic [J_WIDTH-1:0]  w_col;
  logic                w_is_last;
  logic                w_step;
  logic                w_found;
  logic                w_consume;

  assign w_found   = !i_start && (r_state == SCAN_WAIT) && !i_vis_rd_data;
  assign w_consume = !i_start && (r_state == SCAN_HOLD) && i_advance;
  assign w_step    = w_consume || (!i_start && (r_state == SCAN_WAIT) && i_vis_rd_data);

  eda_raster_ptr #(
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_ptr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (i_start),
    .i_step     (w_step),
    .i_num_rows (r_num_rows),
    .i_num_cols (r_num_cols),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_is_last  (w_is_last)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      SCAN_FETCH: w_state_d = SCAN_WAIT;
      SCAN_WAIT: begin
        if (i_vis_rd_data) w_state_d = w_is_last ? SCAN_DONE : SCAN_FETCH;
        else               w_state_d = SCAN_HOLD;
      end
      SCAN_HOLD: begin
        if (i_advance) w_state_d = w_is_last ? SCAN_DONE : SCAN_FETCH;
      end
      default: w_state_d = r_state;
    endcase
    // start aborts whatever is in flight and wins over advance.
    if (i_start) begin
      w_state_d = ((i_num_rows == '0) || (i_num_cols == '0)) ? SCAN_DONE : SCAN_FETCH;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= SCAN_IDLE;
      r_out        <= '0;
      r_num_rows   <= '0;
      r_num_cols   <= '0;
      r_seed_count <= '0;
      r_next_row   <= '0;
      r_next_col   <= '0;
    end else begin
      r_state <= w_state_d;
      r_out   <= scan_decode(w_state_d);
      if (i_start) begin
        r_num_rows   <= i_num_rows;
        r_num_cols   <= i_num_cols;
        r_seed_count <= '0;
      end else if (w_consume) begin
        r_seed_count <= r_seed_count + (ADDR_WIDTH + 1)'(1);
      end
      if (w_found) begin
        r_next_row <= w_row;
        r_next_col <= w_col;
      end
    end
  end

  assign o_vis_rd_en    = r_out.rd_en;
  assign o_vis_rd_addr  = {w_row, w_col};
  assign o_next_row     = r_next_row;
  assign o_next_col     = r_next_col;
  assign o_next_valid   = r_out.next_valid;
  assign o_iterated_all = r_out.done;
  assign o_seed_count   = r_seed_count;
  assign o_busy         = r_out.busy;

endmodule

// File: tb/tb_eda_scan_scheduler.sv
// Directed self-checking bench for eda_scan_scheduler with a 1-cycle-latency visited RAM model.
module tb_eda_scan_scheduler;

  localparam int IW = 6;
  localparam int JW = 6;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW:0]   num_rows;
  logic [JW:0]   num_cols;
  logic          advance;
  logic          vis_rd_en;
  logic [AW-1:0] vis_rd_addr;
  logic          vis_rd_data = 1'b0;
  logic [IW-1:0] next_row;
  logic [JW-1:0] next_col;
  logic          next_valid;
  logic          iterated_all;
  logic [AW:0]   seed_count;
  logic          busy;

  logic vis_mem [0:(1<<AW)-1];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (vis_rd_en) vis_rd_data <= vis_mem[vis_rd_addr];

  eda_scan_scheduler dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_num_rows     (num_rows),
    .i_num_cols     (num_cols),
    .i_advance      (advance),
    .o_vis_rd_en    (vis_rd_en),
    .o_vis_rd_addr  (vis_rd_addr),
    .i_vis_rd_data  (vis_rd_data),
    .o_next_row     (next_row),
    .o_next_col     (next_col),
    .o_next_valid   (next_valid),
    .o_iterated_all (iterated_all),
    .o_seed_count   (seed_count),
    .o_busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic v);
    for (int a = 0; a < (1 << AW); a++) vis_mem[a] = v;
  endtask

  task automatic set_px(input int r, input int c, input logic v);
    vis_mem[r * 64 + c] = v;
  endtask

  task automatic do_start(input int r, input int c);
    num_rows = 7'(r);
    num_cols = 7'(c);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (next_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic pulse_advance();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cycles;
    int   seen;
    int   nv_row [4];
    int   nv_col [4];

    reset = 1'b1; start = 1'b0; advance = 1'b0; num_rows = '0; num_cols = '0;
    fill(1'b1);
    tick(); tick(); tick();
    check("rst_outputs", 32'({vis_rd_en, vis_rd_addr, next_valid, next_row, next_col,
                              iterated_all, busy}), 32'd0);
    check("rst_seed_count", 32'(seed_count), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_read", 32'(vis_rd_en), 32'd0);

    // 2x2, nothing visited: four seeds in raster order.
    fill(1'b0);
    do_start(2, 2);
    check("t1_rd_en_t1", 32'(vis_rd_en), 32'd1);
    check("t1_addr0", 32'(vis_rd_addr), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick(); tick();
    check("t1_valid_t3", 32'(next_valid), 32'd1);
    check("t1_seed0", 32'({next_row, next_col}), 32'd0);
    pulse_advance();
    check("t1_adv_read", 32'(vis_rd_en), 32'd1);
    check("t1_adv_addr", 32'(vis_rd_addr), 32'd1);
    check("t1_count1", 32'(seed_count), 32'd1);
    for (int k = 1; k < 4; k++) begin
      wait_valid(ok);
      check("t1_wait", 32'(ok), 32'd1);
      check("t1_row", 32'(next_row), 32'(k / 2));
      check("t1_col", 32'(next_col), 32'(k % 2));
      pulse_advance();
      if (k == 2) check("t1_not_done", 32'(iterated_all), 32'd0);
    end
    check("t1_done", 32'(iterated_all), 32'd1);
    check("t1_count4", 32'(seed_count), 32'd4);
    check("t1_nv_low", 32'(next_valid), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    tick(); tick();
    check("t1_done_sticky", 32'(iterated_all), 32'd1);

    // 4x4, all visited: 2 cycles per pixel, no seeds.
    fill(1'b1);
    do_start(4, 4);
    cycles = 0; seen = 0;
    while (!iterated_all && cycles < 100) begin
      if (next_valid) seen++;
      tick();
      cycles++;
    end
    check("t2_done_cycle", 32'(cycles + 1), 32'd33);
    check("t2_no_valid", 32'(seen), 32'd0);
    check("t2_count0", 32'(seed_count), 32'd0);

    // 3x5, only (1,4) and (2,0) unvisited; advance held high throughout.
    fill(1'b1);
    set_px(1, 4, 1'b0);
    set_px(2, 0, 1'b0);
    advance = 1'b1;
    do_start(3, 5);
    cycles = 0; seen = 0;
    while (!iterated_all && cycles < 100) begin
      if (next_valid) begin
        if (seen < 4) begin
          nv_row[seen] = int'(next_row);
          nv_col[seen] = int'(next_col);
        end
        seen++;
      end
      tick();
      cycles++;
    end
    advance = 1'b0;
    check("t3_done_cycle", 32'(cycles + 1), 32'd33);
    check("t3_valid_count", 32'(seen), 32'd2);
    check("t3_seed_a", 32'({nv_row[0][7:0], nv_col[0][7:0]}), 32'h0104);
    check("t3_seed_b", 32'({nv_row[1][7:0], nv_col[1][7:0]}), 32'h0200);
    check("t3_count2", 32'(seed_count), 32'd2);

    // Restart from HOLD.
    fill(1'b1);
    set_px(0, 1, 1'b0);
    set_px(0, 2, 1'b0);
    do_start(3, 4);
    wait_valid(ok);
    check("t4_wait_a", 32'(ok), 32'd1);
    check("t4_seed_a", 32'({next_row, next_col}), 32'd1);
    pulse_advance();
    wait_valid(ok);
    check("t4_wait_b", 32'(ok), 32'd1);
    check("t4_seed_b", 32'({next_row, next_col}), 32'd2);
    check("t4_count1", 32'(seed_count), 32'd1);
    advance = 1'b1;
    do_start(2, 2);
    advance = 1'b0;
    check("t4_restart_rd", 32'(vis_rd_en), 32'd1);
    check("t4_restart_addr", 32'(vis_rd_addr), 32'd0);
    check("t4_restart_count", 32'(seed_count), 32'd0);
    check("t4_restart_nv", 32'(next_valid), 32'd0);

    // Zero dimension goes straight to DONE, then 1x1.
    do_start(3, 0);
    check("t5_done", 32'(iterated_all), 32'd1);
    check("t5_no_read", 32'(vis_rd_en), 32'd0);
    check("t5_not_busy", 32'(busy), 32'd0);
    tick();
    check("t5_no_read2", 32'(vis_rd_en), 32'd0);
    set_px(0, 0, 1'b0);
    do_start(1, 1);
    check("t5_rd_1x1", 32'(vis_rd_en), 32'd1);
    tick(); tick();
    check("t5_valid_1x1", 32'(next_valid), 32'd1);
    check("t5_seed_1x1", 32'({next_row, next_col}), 32'd0);
    pulse_advance();
    check("t5_done_1x1", 32'(iterated_all), 32'd1);
    check("t5_count_1x1", 32'(seed_count), 32'd1);

    // Reset during WAIT of pixel (0,1).
    fill(1'b1);
    do_start(2, 2);
    tick(); tick();
    check("t6_addr1", 32'(vis_rd_addr), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_outputs", 32'({vis_rd_en, vis_rd_addr, next_valid, next_row, next_col,
                             iterated_all, busy}), 32'd0);
    check("t6_count", 32'(seed_count), 32'd0);
    advance = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vis_rd_en || busy || next_valid) seen++;
    end
    advance = 1'b0;
    check("t6_quiet", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eda_scan_scheduler.md
Name: eda_scan_scheduler

Overview:
Raster-scan seed scheduler for the regional-max engine. It walks the image row-major from (0,0) and checks each pixel against the visited-flag RAM. It presents the next unvisited pixel to the region controller as {next_row, next_col} and asserts iterated_all once the whole image has been consumed. It replaces free-running row/col counters, so the controller never restarts a region on an already-labelled pixel.

Parameters:
I_WIDTH, 6, row index width
J_WIDTH, 6, column index width
ADDR_WIDTH, 12, pixel address width; must equal I_WIDTH+J_WIDTH; address = {row, col}

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
start  input  1  begin a new image scan; single-cycle pulse
num_rows  input  I_WIDTH+1  image height, latched on start
num_cols  input  J_WIDTH+1  image width, latched on start
advance  input  1  controller consumed the presented seed; driven from the controller's update strobe
vis_rd_en  output  1  visited-RAM read request
vis_rd_addr  output  ADDR_WIDTH  visited-RAM read address
vis_rd_data  input  1  visited flag, valid exactly 1 cycle after vis_rd_en
next_row  output  I_WIDTH  candidate seed row
next_col  output  J_WIDTH  candidate seed column
next_valid  output  1  candidate is unvisited and held stable
iterated_all  output  1  scan complete
seed_count  output  ADDR_WIDTH+1  number of seeds handed out this scan
busy  output  1  scan in progress

Behaviour:
- Reset is synchronous, active-high. Reset values:
  - state IDLE
  - all outputs 0
  - row/col pointers 0
  - latched dimensions 0
- Reset mid-scan aborts the scan with no further RAM reads.
- States: IDLE, FETCH, WAIT, HOLD, DONE (3-bit encoding).
- IDLE or DONE + start:
  - latch num_rows and num_cols; clear row, col and seed_count.
  - if either dimension is 0, go to DONE; otherwise go to FETCH.
- start in any state restarts the scan in the same way (abort). start has priority over advance.
- FETCH (1 cycle): vis_rd_en=1, vis_rd_addr={row,col}; go to WAIT.
- WAIT (1 cycle): sample vis_rd_data.
  - flag=1 (visited): step the pointer. If the pixel was the last one, go to DONE; else go to FETCH.
  - flag=0: go to HOLD.
- HOLD:
  - next_valid=1; next_row/next_col hold the pointer.
  - on advance: seed_count+1, step the pointer; if the pixel was the last one, go to DONE, else go to FETCH.
  - without advance: hold indefinitely.
- Pointer step: col+1. When col+1==num_cols, col=0 and row+1. The last pixel is row==num_rows-1 and col==num_cols-1; no wrap past it.
- DONE: iterated_all=1; next_valid=0; seed_count frozen. iterated_all stays high until the next start or reset.
- busy=1 in FETCH, WAIT and HOLD.
- advance outside HOLD is ignored.
- next_row/next_col keep their last value outside HOLD; they are only meaningful while next_valid=1.
- Latency:
  - start at cycle t: vis_rd_en at t+1; next_valid at t+3 if (0,0) is unvisited.
  - each visited pixel costs 2 cycles.
  - advance at cycle t: next read at t+1.
- The visited RAM is written by the region datapath. A write made during the HOLD of a seed is seen by later FETCHes; no forwarding is required.
- All state and outputs are registered or decoded from state only, with no combinational path from inputs to outputs, except vis_rd_addr, which is a direct function of the pointer registers.

Decomposition:
- Shared package eda_global_define:
  - CFG_I_WIDTH, CFG_J_WIDTH, CFG_ADDR_WIDTH defaults
  - state encoding constants SCAN_IDLE..SCAN_DONE
- Sub-module eda_raster_ptr: row/col pointer with step, clear and is_last outputs. Reusable by the debug readout path.
- Top-level FSM is in eda_scan_scheduler.

Test Plan:
- 2x2 image, all visited flags 0, advance 1 cycle after each next_valid:
  - seeds presented in order (0,0),(0,1),(1,0),(1,1)
  - seed_count=4; iterated_all rises after the 4th advance.
- 4x4 image, all flags 1:
  - no next_valid ever
  - iterated_all at start+1+2*16 cycles; seed_count=0.
- 3x5 image, only (1,4) and (2,0) unvisited, advance immediately:
  - next_valid exactly for (1,4) then (2,0)
  - checks the row wrap at col 4→0; seed_count=2.
- start pulse while in HOLD at (0,2) with num_rows=2, num_cols=2:
  - restarts at (0,0); vis_rd_en the next cycle; seed_count cleared.
- num_cols=0 start: DONE in 1 cycle, no vis_rd_en; then a start with 1x1 and flag 0 gives next_valid for (0,0).
- reset asserted during WAIT:
  - next cycle all outputs 0, state IDLE
  - a later advance produces no activity.
